ula_sequencial: RTL and testbench

ULA_SEQUENCIAL -- requirements
Module: ula_sequencial

---
 rtl/ula_pkg.sv | 24 ++
 rtl/ula_iterativa.sv | 76 +++++++
 rtl/ula_sequencial.sv | 148 ++++++++++++++
 tb/tb_ula_sequencial.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU: operation codes seen by the
// ALU control decoder and the FSM state encoding.
package ula_pkg;

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ITERA  = 2'd1,
    FIM    = 2'd2
  } estado_t;

endpackage

// File: rtl/ula_iterativa.sv
// Bit-serial MUL (shift-add) / DIV (restoring) engine, one bit per cycle.
// fim_o flags the last iteration; resultado_o is the value that iteration produces.
module ula_iterativa #(
  parameter int LARGURA = 32
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               div_i,
  input  logic [LARGURA-1:0] operando_i,
  input  logic [LARGURA-1:0] carga_i,
  output logic               fim_o,
  output logic [LARGURA-1:0] resultado_o
);

  localparam int CW = $clog2(LARGURA);
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

  logic               ativo_q, ativo_d;
  logic [CW-1:0]      cont_q, cont_d;
  logic [LARGURA-1:0] alto_q, alto_d;
  logic [LARGURA-1:0] baixo_q, baixo_d;
  logic [LARGURA:0]   soma;
  logic [LARGURA:0]   resto_desl;
  logic [LARGURA-1:0] resto_sub;
  logic               cabe;

  // alto holds the partial product high half (MUL) or partial remainder (DIV);
  // baixo holds the shifting multiplier/product low half or dividend/quotient.
  always_comb begin
    soma       = {1'b0, alto_q} + (baixo_q[0] ? {1'b0, operando_i} : '0);
    resto_desl = {alto_q, baixo_q[LARGURA-1]};
    cabe       = resto_desl >= {1'b0, operando_i};
    resto_sub  = resto_desl[LARGURA-1:0] - operando_i;
    ativo_d    = ativo_q;
    cont_d     = cont_q;
    alto_d     = alto_q;
    baixo_d    = baixo_q;
    if (start_i) begin
      ativo_d = 1'b1;
      cont_d  = '0;
      alto_d  = '0;
      baixo_d = carga_i;
    end else if (ativo_q) begin
      cont_d = cont_q + 1'b1;
      if (cont_q == ULTIMO) begin
        ativo_d = 1'b0;
      end
      if (div_i) begin
        alto_d  = cabe ? resto_sub : resto_desl[LARGURA-1:0];
        baixo_d = {baixo_q[LARGURA-2:0], cabe};
      end else begin
        alto_d  = soma[LARGURA:1];
        baixo_d = {soma[0], baixo_q[LARGURA-1:1]};
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ativo_q <= 1'b0;
      cont_q  <= '0;
      alto_q  <= '0;
      baixo_q <= '0;
    end else begin
      ativo_q <= ativo_d;
      cont_q  <= cont_d;
      alto_q  <= alto_d;
      baixo_q <= baixo_d;
    end
  end

  assign fim_o       = ativo_q && (cont_q == ULTIMO);
  assign resultado_o = baixo_d;

endmodule

// File: rtl/ula_sequencial.sv
// Sequential ALU: single-cycle ops complete in one cycle, MUL/DIV run through
// the bit-serial engine; results stay registered until the next completion.
module ula_sequencial
  import ula_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         controle_ULA,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  output logic [LARGURA-1:0] resultado,
  output logic               zero,
  output logic               busy,
  output logic               done,
  output logic               erro
);

  localparam int SHW = $clog2(LARGURA);

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] a_q, b_q;
  logic [3:0]         op_q;
  logic [LARGURA-1:0] resultado_q, resultado_d;
  logic               zero_q, zero_d;
  logic               erro_q, erro_d;
  logic [LARGURA-1:0] res_simples;
  logic               erro_simples;
  logic               iterativo;
  logic               captura;
  logic               inicia_iter;
  logic               iter_fim;
  logic [LARGURA-1:0] iter_res;
  logic [SHW-1:0]     desloc;

  assign desloc = B[SHW-1:0];

  always_comb begin
    res_simples  = '0;
    erro_simples = 1'b0;
    case (controle_ULA)
      OP_PASS: res_simples = A;
      OP_ADD:  res_simples = A + B;
      OP_SUB:  res_simples = A - B;
      OP_AND:  res_simples = A & B;
      OP_OR:   res_simples = A | B;
      OP_XOR:  res_simples = A ^ B;
      OP_NOR:  res_simples = ~(A | B);
      OP_SLT:  res_simples = {{(LARGURA-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL:  res_simples = A << desloc;
      OP_SRL:  res_simples = A >> desloc;
      OP_MUL:  res_simples = '0;
      // Only reached when the divisor is zero; real divisions iterate.
      OP_DIV: begin
        res_simples  = '1;
        erro_simples = 1'b1;
      end
      default: begin
        res_simples  = '0;
        erro_simples = 1'b1;
      end
    endcase
  end

  assign iterativo = (controle_ULA == OP_MUL) ||
                     ((controle_ULA == OP_DIV) && (B != '0));

  always_comb begin
    estado_d    = estado_q;
    resultado_d = resultado_q;
    zero_d      = zero_q;
    erro_d      = erro_q;
    captura     = 1'b0;
    inicia_iter = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (start) begin
          captura = 1'b1;
          if (iterativo) begin
            estado_d    = ITERA;
            inicia_iter = 1'b1;
          end else begin
            estado_d    = FIM;
            resultado_d = res_simples;
            zero_d      = (res_simples == '0);
            erro_d      = erro_simples;
          end
        end
      end
      ITERA: begin
        if (iter_fim) begin
          estado_d    = FIM;
          resultado_d = iter_res;
          zero_d      = (iter_res == '0);
          erro_d      = 1'b0;
        end
      end
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      resultado_q <= '0;
      zero_q      <= 1'b1;
      erro_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      resultado_q <= resultado_d;
      zero_q      <= zero_d;
      erro_q      <= erro_d;
      if (captura) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= controle_ULA;
      end
    end
  end

  // The engine loads the shifting operand straight from the inputs on the
  // accept edge; the fixed operand comes from the captured registers.
  ula_iterativa #(
    .LARGURA(LARGURA)
  ) u_iterativa (
    .clock_i    (clock),
    .reset_i    (reset),
    .start_i    (inicia_iter),
    .div_i      (op_q == OP_DIV),
    .operando_i ((op_q == OP_DIV) ? b_q : a_q),
    .carga_i    ((controle_ULA == OP_DIV) ? A : B),
    .fim_o      (iter_fim),
    .resultado_o(iter_res)
  );

  assign resultado = resultado_q;
  assign zero      = zero_q;
  assign erro      = erro_q;
  assign busy      = (estado_q != OCIOSO);
  assign done      = (estado_q == FIM);

endmodule

// File: tb/tb_ula_sequencial.sv
// Directed bench for ula_sequencial: hand-computed vectors, latency and
// handshake checks, illegal codes, divide by zero and reset abort.
module tb_ula_sequencial;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   controle_ULA;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] resultado;
  logic         zero;
  logic         busy;
  logic         done;
  logic         erro;

  int total = 0;
  int bad   = 0;

  localparam int NTAB = 13;
  logic [3:0]   tab_op  [NTAB] = '{4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                   4'b0110, 4'b0111, 4'b0111, 4'b1000, 4'b1001, 4'b1000};
  logic [W-1:0] tab_a   [NTAB] = '{32'hDEADBEEF, 32'hFFFFFFFF, 32'h0, 32'h5, 32'hF0F0F0F0, 32'h0F0F0000,
                                   32'hFFFF0000, 32'hFFFF0000, 32'hFFFFFFFF, 32'h3, 32'h1, 32'h80000000,
                                   32'h80000001};
  logic [W-1:0] tab_b   [NTAB] = '{32'h12345678, 32'h1, 32'h1, 32'h5, 32'hFF00FF00, 32'h000000F0,
                                   32'h0FF00FF0, 32'h0000FFFF, 32'h1, 32'hFFFFFFFF, 32'h24, 32'h1F,
                                   32'h1};
  logic [W-1:0] tab_exp [NTAB] = '{32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hF000F000, 32'h0F0F00F0,
                                   32'hF00F0FF0, 32'h0, 32'h1, 32'h0, 32'h10, 32'h1, 32'h2};

  ula_sequencial #(.LARGURA(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .controle_ULA(controle_ULA),
    .A           (A),
    .B           (B),
    .resultado   (resultado),
    .zero        (zero),
    .busy        (busy),
    .done        (done),
    .erro        (erro)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one cycle; returns #1 after the accept edge (cycle 1).
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    controle_ULA = op;
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    controle_ULA = 4'b0000;
    A = '0;
    B = '0;
    tick();
    tick();
    total++;
    if (resultado !== 32'h0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || erro !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got res=%h z=%b busy=%b done=%b erro=%b want res=0 z=1 busy=0 done=0 erro=0",
               resultado, zero, busy, done, erro);
    end
    reset = 1'b0;
    tick();
    $display("reset: res=%h z=%b busy=%b", resultado, zero, busy);
  endtask

  task automatic test_add();
    issue(4'b0001, 32'h7FFFFFFF, 32'h1);
    total++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL add_latency: got done=%b busy=%b want done=1 busy=1 at cycle 1", done, busy);
    end
    total++;
    if (resultado !== 32'h80000000 || zero !== 1'b0 || erro !== 1'b0) begin
      bad++;
      $display("FAIL add_result: got res=%h z=%b erro=%b want res=80000000 z=0 erro=0", resultado, zero, erro);
    end
    $display("add 7fffffff+1 -> res=%h z=%b", resultado, zero);
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || resultado !== 32'h80000000) begin
      bad++;
      $display("FAIL add_after: got done=%b busy=%b res=%h want done=0 busy=0 res=80000000", done, busy, resultado);
    end
  endtask

  task automatic test_table();
    for (int i = 0; i < NTAB; i++) begin
      issue(tab_op[i], tab_a[i], tab_b[i]);
      total++;
      if (done !== 1'b1 || resultado !== tab_exp[i] || zero !== (tab_exp[i] == 32'h0) || erro !== 1'b0) begin
        bad++;
        $display("FAIL table_%0d: op=%b got done=%b res=%h z=%b erro=%b want done=1 res=%h z=%b erro=0",
                 i, tab_op[i], done, resultado, zero, erro, tab_exp[i], (tab_exp[i] == 32'h0));
      end
      $display("op=%b a=%h b=%h -> res=%h z=%b erro=%b", tab_op[i], tab_a[i], tab_b[i], resultado, zero, erro);
      tick();
    end
  endtask

  task automatic test_mul();
    issue(4'b1010, 32'h00010000, 32'h00010001);
    for (int c = 1; c <= 33; c++) begin
      if (c <= 32) begin
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("FAIL mul_busy_c%0d: got busy=%b done=%b want busy=1 done=0", c, busy, done);
        end
      end else begin
        total++;
        if (done !== 1'b1 || resultado !== 32'h00010000 || zero !== 1'b0 || erro !== 1'b0) begin
          bad++;
          $display("FAIL mul_done_c33: got done=%b res=%h z=%b erro=%b want done=1 res=00010000 z=0 erro=0",
                   done, resultado, zero, erro);
        end
      end
      // Requests while busy (and in the done cycle) must be dropped.
      if (c == 5 || c == 20 || c == 33) begin
        controle_ULA = 4'b0001;
        A = 32'h1;
        B = 32'h1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || resultado !== 32'h00010000) begin
      bad++;
      $display("FAIL mul_ignored_start: got busy=%b done=%b res=%h want busy=0 done=0 res=00010000",
               busy, done, resultado);
    end
    $display("mul 10000*10001 -> res=%h", resultado);
  endtask

  task automatic test_div();
    int first_done;
    logic [W-1:0] res_seen;
    logic err_seen;
    first_done = 0;
    res_seen = '0;
    err_seen = 1'b0;
    issue(4'b1011, 32'd100, 32'd7);
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin
        first_done = c;
        res_seen = resultado;
        err_seen = erro;
        break;
      end
      tick();
    end
    total++;
    if (first_done != 33) begin
      bad++;
      $display("FAIL div_latency: got done at cycle %0d want 33", first_done);
    end
    total++;
    if (res_seen !== 32'd14 || err_seen !== 1'b0) begin
      bad++;
      $display("FAIL div_result: got res=%h erro=%b want res=0000000e erro=0", res_seen, err_seen);
    end
    $display("div 100/7 -> res=%h at cycle %0d", res_seen, first_done);
    tick();

    issue(4'b1011, 32'd5, 32'd0);
    total++;
    if (done !== 1'b1 || resultado !== 32'hFFFFFFFF || erro !== 1'b1 || zero !== 1'b0) begin
      bad++;
      $display("FAIL div_zero: got done=%b res=%h erro=%b z=%b want done=1 res=ffffffff erro=1 z=0",
               done, resultado, erro, zero);
    end
    $display("div 5/0 -> res=%h erro=%b", resultado, erro);
    tick();
  endtask

  task automatic test_illegal();
    issue(4'b1101, 32'h12345678, 32'h9);
    total++;
    if (done !== 1'b1 || resultado !== 32'h0 || zero !== 1'b1 || erro !== 1'b1) begin
      bad++;
      $display("FAIL illegal_code: got done=%b res=%h z=%b erro=%b want done=1 res=0 z=1 erro=1",
               done, resultado, zero, erro);
    end
    $display("op=1101 -> res=%h erro=%b", resultado, erro);
    tick();
    issue(4'b0001, 32'd2, 32'd3);
    total++;
    if (done !== 1'b1 || resultado !== 32'd5 || zero !== 1'b0 || erro !== 1'b0) begin
      bad++;
      $display("FAIL illegal_recover: got done=%b res=%h z=%b erro=%b want done=1 res=5 z=0 erro=0",
               done, resultado, zero, erro);
    end
    $display("add 2+3 -> res=%h erro=%b", resultado, erro);
    tick();
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    saw_done = 1'b0;
    issue(4'b1010, 32'd3, 32'd5);
    for (int c = 1; c < 10; c++) begin
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (resultado !== 32'h0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || erro !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: got res=%h z=%b busy=%b done=%b erro=%b want res=0 z=1 busy=0 done=0 erro=0",
               resultado, zero, busy, done, erro);
    end
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      tick();
    end
    total++;
    if (saw_done !== 1'b0 || resultado !== 32'h0) begin
      bad++;
      $display("FAIL abort_no_done: got activity=%b res=%h want activity=0 res=0", saw_done, resultado);
    end
    $display("mul aborted by reset -> res=%h", resultado);
    issue(4'b0001, 32'h10, 32'h20);
    total++;
    if (done !== 1'b1 || resultado !== 32'h30 || erro !== 1'b0) begin
      bad++;
      $display("FAIL abort_recover: got done=%b res=%h erro=%b want done=1 res=30 erro=0", done, resultado, erro);
    end
    $display("add 10+20 -> res=%h", resultado);
    tick();
  endtask

  task automatic test_back_to_back();
    issue(4'b0001, 32'd1, 32'd2);
    // Request held from the done cycle onward: dropped in FIM, accepted next cycle.
    controle_ULA = 4'b0101;
    A = 32'hFF;
    B = 32'h0F;
    start = 1'b1;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || resultado !== 32'd3) begin
      bad++;
      $display("FAIL b2b_fim_ignored: got done=%b busy=%b res=%h want done=0 busy=0 res=3", done, busy, resultado);
    end
    tick();
    start = 1'b0;
    total++;
    if (done !== 1'b1 || resultado !== 32'hF0) begin
      bad++;
      $display("FAIL b2b_accept: got done=%b res=%h want done=1 res=f0", done, resultado);
    end
    $display("xor ff^0f back-to-back -> res=%h", resultado);
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_table();
    test_mul();
    test_div();
    test_illegal();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
